// File: rtl/mac_array_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_array_pkg
// Description : Shared types and helpers for the multi-lane integer MAC
//               engine (mac_array_int).
//               - beat_tag_t    : per-beat pipeline tags {valid, first, last}
//               - sat_result_t  : saturated value plus clip flag
//               - min_acc_bits(): smallest accumulator width that never wraps
//               - sat_int()     : clamp a signed value into out_bits
// Revision    : 1.0 - initial release
// ============================================================================
package mac_array_pkg;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } beat_tag_t;

    typedef struct packed {
        logic               sat;
        logic signed [63:0] value;
    } sat_result_t;

    // Product (2*bits) + growth over every product summed in one window + sign.
    function automatic int min_acc_bits(input int bits, input int lanes, input int max_beats);
        return 2 * bits + $clog2(lanes * max_beats) + 1;
    endfunction

    // Clamp to [-2^(out_bits-1), 2^(out_bits-1)-1]; out_bits must be 2..63.
    function automatic sat_result_t sat_int(input logic signed [63:0] value, input int out_bits);
        sat_result_t        r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_bits - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_bits - 1));
        r.sat = 1'b1;
        if (value > hi) begin
            r.value = hi;
        end else if (value < lo) begin
            r.value = lo;
        end else begin
            r.value = value;
            r.sat   = 1'b0;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_sum_int.sv
`default_nettype none
// ============================================================================
// Module      : lane_sum_int
// Description : Combinational sign-extended sum of Lanes signed operands.
// Ports       : prods_i [Lanes*InBits] packed signed operands, lane k at
//                       bits [k*InBits +: InBits]
//               sum_o   [InBits+$clog2(Lanes)] signed sum of all lanes
// Revision    : 1.0 - initial release
// ============================================================================
module lane_sum_int #(
    parameter  int Lanes   = 4,
    parameter  int InBits  = 16,
    localparam int SumBits = InBits + $clog2(Lanes)
) (
    input  logic [Lanes*InBits-1:0]   prods_i,
    output logic signed [SumBits-1:0] sum_o
);

    // Every operand is widened to the full sum width before adding, so the
    // result cannot overflow; the tool is free to balance the chain.
    always_comb begin
        sum_o = '0;
        for (int k = 0; k < Lanes; k++) begin
            sum_o = sum_o + SumBits'($signed(prods_i[k*InBits +: InBits]));
        end
    end

endmodule
`default_nettype wire

// File: rtl/mac_array_int.sv
`default_nettype none
// ============================================================================
// Module      : mac_array_int
// Description : Pipelined multi-lane integer multiply-accumulate engine.
//               Each accepted beat carries Lanes signed value/weight pairs;
//               products are summed and accumulated over a window of len_i
//               beats, seeded with bias_i, and one saturated result is
//               emitted per window through a valid/ready handshake.
//               Pipeline: S1 products -> S2 lane sum -> S3 accumulate/output.
// Ports       : clk_i, rst_i (sync, active high)
//               in_valid_i / in_ready_o      input beat handshake
//               value_i, mult_i [Lanes*Bits] packed signed lanes
//               bias_i [AccBits]             seed, first beat only
//               len_i                        window length, first beat only
//               out_valid_o / out_ready_i    result handshake
//               mac_o [OutBits], sat_o       saturated result and clip flag
// Revision    : 1.0 - initial release
// ============================================================================
module mac_array_int
    import mac_array_pkg::*;
#(
    parameter int Bits     = 8,
    parameter int Lanes    = 4,
    parameter int MaxBeats = 25,
    parameter int AccBits  = 32,
    parameter int OutBits  = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [Lanes*Bits-1:0]       value_i,
    input  logic [Lanes*Bits-1:0]       mult_i,
    input  logic [AccBits-1:0]          bias_i,
    input  logic [$clog2(MaxBeats+1)-1:0] len_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [OutBits-1:0]          mac_o,
    output logic                        sat_o
);

    localparam int LEN_W  = $clog2(MaxBeats + 1);
    localparam int PROD_W = 2 * Bits;
    localparam int SUM_W  = PROD_W + $clog2(Lanes);

    localparam logic [LEN_W-1:0] C_ONE     = LEN_W'(1);
    localparam logic [LEN_W-1:0] C_MAX_LEN = LEN_W'(MaxBeats);

    if (AccBits < min_acc_bits(Bits, Lanes, MaxBeats)) begin : g_acc_too_narrow
        $error("mac_array_int: AccBits too small for Bits/Lanes/MaxBeats");
    end
    if (OutBits > AccBits || AccBits > 64 || OutBits < 2) begin : g_bad_widths
        $error("mac_array_int: need 2 <= OutBits <= AccBits <= 64");
    end

    // ------------------------------------------------------------------------
    // Handshake and window counter
    // ------------------------------------------------------------------------
    logic             w_stall;
    logic             w_accept;
    logic             w_first;
    logic             w_last;
    logic [LEN_W-1:0] w_len_eff;
    logic [LEN_W-1:0] w_cur_len;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] r_len;

    assign w_stall    = out_valid_o & ~out_ready_i;
    assign in_ready_o = ~w_stall;
    assign w_accept   = in_valid_i & ~w_stall;

    assign w_len_eff = (len_i == '0)       ? C_ONE     :
                       (len_i > C_MAX_LEN) ? C_MAX_LEN : len_i;
    assign w_first   = (r_cnt == '0);
    // The first beat compares against the incoming length so len=1 is last too.
    assign w_cur_len = w_first ? w_len_eff : r_len;
    assign w_last    = (r_cnt == w_cur_len - C_ONE);

    // ------------------------------------------------------------------------
    // Lane products (feed S1)
    // ------------------------------------------------------------------------
    logic [Lanes*PROD_W-1:0] w_prods;

    for (genvar k = 0; k < Lanes; k++) begin : g_lane
        assign w_prods[k*PROD_W +: PROD_W] =
            PROD_W'($signed(value_i[k*Bits +: Bits])) *
            PROD_W'($signed(mult_i[k*Bits +: Bits]));
    end

    // ------------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------------
    beat_tag_t                   r_s1_tag;
    logic [Lanes*PROD_W-1:0]     r_s1_prods;
    logic signed [AccBits-1:0]   r_s1_bias;
    beat_tag_t                   r_s2_tag;
    logic signed [SUM_W-1:0]     r_s2_sum;
    logic signed [AccBits-1:0]   r_s2_bias;
    logic signed [AccBits-1:0]   r_acc;
    logic                        r_out_valid;
    logic [OutBits-1:0]          r_mac;
    logic                        r_sat;

    logic signed [SUM_W-1:0]     w_lane_sum;
    logic signed [AccBits-1:0]   w_acc_base;
    logic signed [AccBits-1:0]   w_acc_next;
    sat_result_t                 w_sat;

    lane_sum_int #(
        .Lanes  (Lanes),
        .InBits (PROD_W)
    ) u_lane_sum (
        .prods_i (r_s1_prods),
        .sum_o   (w_lane_sum)
    );

    always_comb begin
        w_acc_base = r_s2_tag.first ? r_s2_bias : r_acc;
        w_acc_next = w_acc_base + AccBits'(r_s2_sum);
        w_sat      = sat_int(64'(w_acc_next), OutBits);
    end

    // Only the low OutBits of the clamped value are meaningful.
    if (OutBits < 64) begin : g_sat_unused
        logic w_unused_sat_hi;
        assign w_unused_sat_hi = ^w_sat.value[63:OutBits];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt       <= '0;
            r_len       <= C_ONE;
            r_s1_tag    <= '0;
            r_s1_prods  <= '0;
            r_s1_bias   <= '0;
            r_s2_tag    <= '0;
            r_s2_sum    <= '0;
            r_s2_bias   <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_mac       <= '0;
            r_sat       <= 1'b0;
        end else if (!w_stall) begin
            if (w_accept) begin
                r_cnt <= w_last ? '0 : r_cnt + C_ONE;
                if (w_first) begin
                    r_len     <= w_len_eff;
                    r_s1_bias <= bias_i;
                end
            end

            // S1: products with tags; bias rides along with its first beat.
            r_s1_tag   <= '{valid: w_accept, first: w_first, last: w_last};
            r_s1_prods <= w_prods;

            // S2: lane sum.
            r_s2_tag  <= r_s1_tag;
            r_s2_sum  <= w_lane_sum;
            r_s2_bias <= r_s1_bias;

            // S3: accumulate and, on the last beat, load the output register.
            if (r_s2_tag.valid) begin
                r_acc <= w_acc_next;
            end
            if (r_s2_tag.valid && r_s2_tag.last) begin
                r_out_valid <= 1'b1;
                r_mac       <= w_sat.value[OutBits-1:0];
                r_sat       <= w_sat.sat;
            end else if (out_ready_i) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid_o = r_out_valid;
    assign mac_o       = r_mac;
    assign sat_o       = r_sat;

endmodule
`default_nettype wire

// File: doc/mac_array_int.md
# mac_array_int

Multi-lane, pipelined integer multiply-accumulate engine for the convolution layer. Each accepted beat carries `Lanes` signed value/weight pairs. The block multiplies the pairs, sums them, and accumulates over a runtime-selected window of beats (one kernel) starting from a bias. At the end of each window it emits one saturated result through a valid/ready handshake. It supersedes the single-lane, externally chained MAC inside the convolver, adding window counting, bias seeding, backpressure and output saturation.

## Interface
- `Bits`, 8: signed width of each value and weight lane.
- `Lanes`, 4: value/weight pairs per beat.
- `MaxBeats`, 25: maximum window length in beats.
- `AccBits`, 32: accumulator width. Elaboration error if less than 2*Bits+$clog2(Lanes*MaxBeats)+1.
- `OutBits`, 16: result width, with `OutBits` ≤ `AccBits`.
- `clk_i` in 1: single clock; all logic on the rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `in_valid_i` in 1: input beat valid.
- `in_ready_o` out 1: block accepts a beat when this and `in_valid_i` are both high.
- `value_i` in Lanes*Bits: packed signed values; lane k occupies bits [k*Bits +: Bits].
- `mult_i` in Lanes*Bits: packed signed weights, same layout as `value_i`.
- `bias_i` in AccBits: signed accumulator seed; sampled on the first beat of a window only.
- `len_i` in $clog2(MaxBeats+1): window length; sampled on the first beat of a window only.
- `out_valid_o` out 1: result valid.
- `out_ready_i` in 1: downstream accepts the result.
- `mac_o` out OutBits: signed, saturated window result.
- `sat_o` out 1: `mac_o` was clipped; qualified by `out_valid_o`.

## Operation
- **Stall rule.** `stall = out_valid_o & ~out_ready_i` and `in_ready_o = ~stall`. While stalled, every pipeline register holds its value.
- **Window counter** (input side):
  - `cnt` runs 0..len-1. A beat is *first* when `cnt==0`; on that beat `len_i` and `bias_i` are latched.
  - A beat is *last* when `cnt==len-1`. On the last beat `cnt` returns to 0; otherwise `cnt` increments.
  - `len_i==0` is treated as 1. `len_i>MaxBeats` is clamped to `MaxBeats`.
- **S1** (products): `p[k] = value[k]*mult[k]`, full 2*Bits signed. Registered together with the valid, first and last tags and the bias.
- **S2** (lane sum): sign-extended sum of all p[k], width 2*Bits+$clog2(Lanes). Registered with the tags.
- **S3** (accumulate):
  - If S2 is valid: `acc <= (first ? bias : acc) + sum`. All operands are sign-extended to AccBits. Wrap cannot occur given the AccBits rule.
  - If S2 is valid and last: the output register loads `mac_o` = acc_next saturated to [-2^(OutBits-1), 2^(OutBits-1)-1]. `sat_o` = 1 when clipped. `out_valid_o` is set to 1.
- **Output handshake:**
  - `out_valid_o` clears when `out_ready_i` is high and no new last result loads in the same cycle.
  - A new load and the draining of the old result in the same cycle is legal. The new result replaces the old one and `out_valid_o` stays 1.
  - `mac_o` and `sat_o` hold while `out_valid_o` is high and `out_ready_i` is low.
- **Reset values:**
  - `out_valid_o`=0, `mac_o`=0, `sat_o`=0; `in_ready_o`=1 from the first cycle after reset.
  - All stage valids=0, `cnt`=0, `acc`=0.
- **Reset mid-window:** the partial window is discarded; the next accepted beat is a first beat.

## Timing
- **Latency:** 3 cycles. A last beat accepted in cycle t gives `out_valid_o` high in cycle t+3, with no stall.
- **Throughput:** one beat per cycle. With len=1 and `out_ready_i` held high, one result per cycle.
- **Window boundaries:** back-to-back windows have no bubble. The first beat of window n+1 may directly follow the last beat of window n.
- **Stalls:** each stall cycle adds exactly one cycle to the latency of every in-flight beat. No beat is dropped or duplicated.

## Structure
- **Package `mac_array_pkg`:**
  - function `sat_int(value, out_bits)`;
  - function returning the minimum AccBits;
  - packed struct `beat_tag_t` {valid, first, last}.
- **Sub-module `lane_sum_int`:** combinational sign-extended adder tree over `Lanes` products, parametrised by `Lanes` and input width. S1 through S3 and the counter stay in `mac_array_int`.

## Test plan
All scenarios use the defaults (Bits=8, Lanes=4, MaxBeats=25, AccBits=32, OutBits=16) unless noted.
1. **Single-beat window:** len=1, values {1,2,3,4}, weights {5,6,7,8}, bias 10 → `mac_o`=80, `sat_o`=0, `out_valid_o` high 3 cycles after acceptance.
2. **Saturation:**
   - len=25, all values -128, weights -128, bias 0 → acc=1,638,400, `mac_o`=32767, `sat_o`=1.
   - Same with weights 127 → `mac_o`=-32768, `sat_o`=1.
3. **Back-to-back windows:** len=2, continuous valid beats, `out_ready_i`=1.
   - Window A: bias 0, beats all-ones (value 1, weight 1) → 8.
   - Window B: bias 100, beats value 2, weight 1 → 116.
   - Results appear on consecutive-window cadence with no bubble and no carry-over of A into B.
4. **Backpressure:** hold `out_ready_i` low for 5 cycles while a result is valid and more beats are pending.
   - `in_ready_o`=0 in those cycles; `mac_o` holds stable.
   - After release, all later results match the golden model in order.
5. **Reset mid-window:** len=3; pulse `rst_i` for 1 cycle after 2 beats; then send a fresh len=1 window with values {1,0,0,0}, weights {3,0,0,0}, bias 0.
   - No output appears for the aborted window.
   - The fresh window gives `mac_o`=3.
6. **Length edge cases:**
   - len_i=0 → behaves as len=1.
   - len_i=31 → clamped to 25: a result is produced after exactly 25 beats.
